// File: rtl/ttuart_tx_buffered_if.sv
// Byte write port of the buffered UART transmitter (valid/ready handshake).
interface ttuart_tx_buffered_if;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;

  modport master (output wr_data, output wr_valid, input wr_ready);
  modport slave  (input wr_data, input wr_valid, output wr_ready);
endinterface

// File: rtl/ttuart_tx_buffered.sv
// Buffered 8N1 UART transmitter: write-port FIFO feeding a serializer that
// sends queued bytes back-to-back, LSB first, on a registered idle-high line.
module ttuart_tx_buffered #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUDRATE   = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  ttuart_tx_buffered_if.slave           wr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          tx_data_out,
  output logic                          tx_busy,
  output logic                          tx_data_done
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUDRATE;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   LVL_FULL  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] baud_cnt, baud_nx;
  logic [2:0]    bit_cnt, bit_nx;
  logic [7:0]    shift, shift_nx;
  logic          line_nx, pop, push, baud_last, has_data;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;

  assign wr.wr_ready   = (fifo_level != LVL_FULL);
  assign push          = wr.wr_valid && wr.wr_ready;
  assign has_data      = (fifo_level != '0);
  assign baud_last     = (baud_cnt == BAUD_LAST);
  assign tx_busy       = (state != IDLE);
  assign tx_data_done  = (state == STOP) && baud_last;

  always_comb begin
    state_nx = state;
    baud_nx  = baud_cnt + 1'b1;
    bit_nx   = bit_cnt;
    shift_nx = shift;
    pop      = 1'b0;
    line_nx  = 1'b1;
    case (state)
      IDLE: begin
        baud_nx = '0;
        if (has_data) begin
          pop      = 1'b1;
          shift_nx = mem[rptr];
          bit_nx   = '0;
          state_nx = START;
          line_nx  = 1'b0;
        end
      end
      START: begin
        line_nx = 1'b0;
        if (baud_last) begin
          baud_nx  = '0;
          state_nx = DATA;
          line_nx  = shift[0];
        end
      end
      DATA: begin
        line_nx = shift[0];
        if (baud_last) begin
          baud_nx = '0;
          if (bit_cnt == 3'd7) begin
            state_nx = STOP;
            line_nx  = 1'b1;
          end else begin
            shift_nx = shift >> 1;
            bit_nx   = bit_cnt + 3'd1;
            line_nx  = shift[1];
          end
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_nx = '0;
          // Pop decision uses the registered level: a same-cycle write waits.
          if (has_data) begin
            pop      = 1'b1;
            shift_nx = mem[rptr];
            bit_nx   = '0;
            state_nx = START;
            line_nx  = 1'b0;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      tx_data_out <= 1'b1;
      wptr        <= '0;
      rptr        <= '0;
      fifo_level  <= '0;
    end else begin
      state       <= state_nx;
      baud_cnt    <= baud_nx;
      bit_cnt     <= bit_nx;
      shift       <= shift_nx;
      tx_data_out <= line_nx;
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Storage carries no reset; the pointers alone define its contents.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wr.wr_data;
  end
endmodule

// File: doc/ttuart_tx_buffered.md
# ttuart_tx_buffered

Buffered 8N1 UART transmitter: accepts bytes on a valid/ready write port into a FIFO and serializes them onto the TX line back-to-back, LSB first. It is the transmit-side counterpart to the UART receive path and sits between on-chip byte producers and the `tx_data_out` pad. Producers can burst up to `FIFO_DEPTH` bytes without waiting for each frame to complete.

## Interface
- `CLK_FREQ`, default 100000000: clock frequency in Hz.
- `BAUDRATE`, default 115200: line rate in Hz. `CLKS_PER_BIT = CLK_FREQ / BAUDRATE`, integer-truncated, must be ≥ 2.
- `FIFO_DEPTH`, default 8: FIFO entries. Power of two, ≥ 2.
- `clk` input, 1 bit: single clock domain.
- `rst_n` input, 1 bit: reset, synchronous, active-low.
- `wr_data` input, 8 bits: byte to enqueue.
- `wr_valid` input, 1 bit: write request.
- `wr_ready` output, 1 bit: FIFO not full. Equals `fifo_level != FIFO_DEPTH`.
- `fifo_level` output, clog2(FIFO_DEPTH)+1 bits: registered count of queued bytes. Excludes the byte being shifted.
- `tx_data_out` output, 1 bit: serial line, idle high.
- `tx_busy` output, 1 bit: FSM not in IDLE.
- `tx_data_done` output, 1 bit: one-cycle pulse at the end of each stop bit.

## Operation
- Write: a byte is enqueued on a rising edge where `wr_valid && wr_ready`. Writes while `wr_ready=0` are dropped, with no side effects.
- FIFO:
  - Circular buffer with wrapping read/write pointers.
  - Push and pop in the same cycle leave `fifo_level` unchanged.
  - Push is never accepted at full. Pop never occurs at empty.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: line high. If `fifo_level != 0`: pop the head into the shift register, clear the bit counter and baud counter, go to START.
  - START: line 0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: line = shift[0]. Hold each bit `CLKS_PER_BIT` cycles, then shift right. After 8 bits, go to STOP.
  - STOP: line 1 for `CLKS_PER_BIT` cycles. On the last cycle, assert `tx_data_done`. If `fifo_level != 0`, pop and go to START (no idle gap). Otherwise go to IDLE.
- Baud counter: counts 0..`CLKS_PER_BIT`-1 and is reset at each state entry. The bit counter is 3 bits.
- `tx_data_out` is registered (glitch-free).

## Timing
- Reset values (on the first edge with `rst_n=0`):
  - `tx_data_out=1`, `tx_busy=0`, `tx_data_done=0`.
  - `fifo_level=0`, so `wr_ready=1`. Pointers 0, FSM IDLE.
- Write into an empty, idle block accepted at edge t:
  - `fifo_level=1` after t.
  - Pop at t+1.
  - `tx_data_out=0` and `tx_busy=1` after t+1, so the start bit begins 2 cycles after acceptance.
- Frame length: exactly 10·`CLKS_PER_BIT` cycles. `tx_data_done` is high during the final cycle of STOP.
- Back-to-back frames: the next start bit follows the last stop-bit cycle directly.
- A byte written during the last STOP cycle is not seen by that cycle's pop decision. It follows after 1 idle cycle plus 1 pop cycle.
- Reset mid-frame: the line returns high and the FIFO is flushed on the reset edge. The partial frame is abandoned and no `tx_data_done` is generated.
- `fifo_level` decrements on the pop edge.
- Simultaneous push and pop at `fifo_level=FIFO_DEPTH` cannot occur, because `wr_ready=0`.

## Test plan
Unless stated, params are CLK_FREQ=10000000, BAUDRATE=1000000 (10 clk/bit), FIFO_DEPTH=8.
- **Single byte:** write 0xA5 to an idle block.
  - Line reads 0,1,0,1,0,0,1,0,1,1, each held 10 cycles, with the start bit 2 cycles after acceptance.
  - One `tx_data_done` pulse 100 cycles after the start-bit edge minus 1.
  - `tx_busy` deasserts after that.
- **Back-to-back:** write 0x00 then 0xFF on consecutive cycles.
  - Line reads 0×90 cycles, 1×10, 0×10, 1×90, with no idle cycle between frames.
  - Two `tx_data_done` pulses, 100 cycles apart.
- **Full FIFO:** hold `wr_valid` with data 0x01..0x0A.
  - 0x01 is popped.
  - `fifo_level` reaches 8 with 0x02..0x09 and `wr_ready=0`; 0x0A is not accepted.
  - All 9 accepted bytes are transmitted in order.
- **Simultaneous push/pop:** with `fifo_level=3`, write during the STOP last cycle. `fifo_level` stays 3 and the write pointer and read pointer both advance.
- **Reset mid-frame:** assert `rst_n=0` for 1 cycle during DATA bit 4 with 5 bytes queued.
  - Next cycle: `tx_data_out=1`, `fifo_level=0`, `tx_busy=0`, no `tx_data_done`.
  - Line stays idle with no new writes.
- **Real divider:** with CLK_FREQ=100000000 and BAUDRATE=115200, each bit is held 868 cycles and the frame is 8680 cycles.
